// File: rtl/mem_stage_if.sv
// EX -> MEM stage bundle: ID/EX control bits and EX datapath results.
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_mem2reg;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_iszerobranch;
  logic        ex_isunconbranch;
  logic [31:0] ex_alu_result;
  logic        ex_alu_zero;
  logic [31:0] ex_store_data;
  logic [31:0] ex_jump_pc;
  logic [4:0]  ex_write_reg;

  modport master (
    output ex_valid, ex_regwrite, ex_mem2reg, ex_memread, ex_memwrite,
           ex_iszerobranch, ex_isunconbranch, ex_alu_result, ex_alu_zero,
           ex_store_data, ex_jump_pc, ex_write_reg
  );

  modport slave (
    input  ex_valid, ex_regwrite, ex_mem2reg, ex_memread, ex_memwrite,
           ex_iszerobranch, ex_isunconbranch, ex_alu_result, ex_alu_zero,
           ex_store_data, ex_jump_pc, ex_write_reg
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, word-addressed data memory, MEM/WB register.
// Optional alignment checking is enabled with `define MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic        clk,
  input  logic        nreset,
  mem_stage_if.slave  ex,
  output logic        pcsrc,
  output logic [31:0] jump_pc,
  output logic        exmem_regwrite,
  output logic [4:0]  exmem_write_reg,
  output logic [31:0] exmem_alu_result,
  output logic        memwb_regwrite,
  output logic [4:0]  memwb_write_reg,
  output logic [31:0] write_reg_data,
  output logic        misalign_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam logic [RW-1:0] XZR = RW'(31);

  // EX/MEM register
  logic          em_regwrite, em_mem2reg, em_memread, em_memwrite;
  logic          em_iszerobranch, em_isunconbranch, em_alu_zero;
  logic [DW-1:0] em_alu_result, em_store_data, em_jump_pc;
  logic [RW-1:0] em_write_reg;

  // MEM/WB register
  logic          wb_regwrite, wb_mem2reg;
  logic [RW-1:0] wb_write_reg;
  logic [DW-1:0] wb_alu_result, wb_load_data;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] idx_c;
  logic          misalign_c;
  logic          mem_we_c;

  assign idx_c = em_alu_result[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  assign misalign_c = (em_memread | em_memwrite) & (em_alu_result[1:0] != 2'b00);

  // Sticky until reset so software can poll after the fact.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)         misalign_q <= 1'b0;
    else if (misalign_c) misalign_q <= 1'b1;
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_c   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Gating on nreset drops a store that is in flight when reset asserts.
  assign mem_we_c = em_memwrite & ~misalign_c & nreset;

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= em_store_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      em_regwrite      <= 1'b0;
      em_mem2reg       <= 1'b0;
      em_memread       <= 1'b0;
      em_memwrite      <= 1'b0;
      em_iszerobranch  <= 1'b0;
      em_isunconbranch <= 1'b0;
      em_alu_zero      <= 1'b0;
      em_alu_result    <= '0;
      em_store_data    <= '0;
      em_jump_pc       <= '0;
      em_write_reg     <= '0;
    end else begin
      // Bubble: an invalid slot carries its data but never its control bits.
      em_regwrite      <= ex.ex_valid & ex.ex_regwrite;
      em_mem2reg       <= ex.ex_valid & ex.ex_mem2reg;
      em_memread       <= ex.ex_valid & ex.ex_memread;
      em_memwrite      <= ex.ex_valid & ex.ex_memwrite;
      em_iszerobranch  <= ex.ex_valid & ex.ex_iszerobranch;
      em_isunconbranch <= ex.ex_valid & ex.ex_isunconbranch;
      em_alu_zero      <= ex.ex_alu_zero;
      em_alu_result    <= ex.ex_alu_result;
      em_store_data    <= ex.ex_store_data;
      em_jump_pc       <= ex.ex_jump_pc;
      em_write_reg     <= ex.ex_write_reg;
    end
  end

  // Memory read samples the pre-write word, giving read-before-write on a combined op.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wb_regwrite   <= 1'b0;
      wb_mem2reg    <= 1'b0;
      wb_write_reg  <= '0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
    end else begin
      wb_regwrite   <= em_regwrite & (em_write_reg != XZR);
      wb_mem2reg    <= em_mem2reg;
      wb_write_reg  <= em_write_reg;
      wb_alu_result <= em_alu_result;
      if (em_memread) wb_load_data <= misalign_c ? '0 : mem[idx_c];
    end
  end

  assign pcsrc            = em_isunconbranch | (em_iszerobranch & em_alu_zero);
  assign jump_pc          = em_jump_pc;
  assign exmem_regwrite   = em_regwrite;
  assign exmem_write_reg  = em_write_reg;
  assign exmem_alu_result = em_alu_result;
  assign memwb_regwrite   = wb_regwrite;
  assign memwb_write_reg  = wb_write_reg;
  assign write_reg_data   = wb_mem2reg ? wb_load_data : wb_alu_result;

endmodule
